// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: A - B over WIDTH cycles, LSB first.
// Optional macro SERIAL_SUB_SAT_EN clamps a borrowing result to zero.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             bo_out
);

  localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             bor;
  logic [CntW-1:0]  cnt;

  logic             h1;
  logic             g1;
  logic             d;
  logic             g2;
  logic             bor_nxt;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] diff_fin;

  // Full-subtract cell built from two cascaded half-subtract cells.
  always_comb begin
    h1       = a_sh[0] ^ b_sh[0];
    g1       = ~a_sh[0] & b_sh[0];
    d        = h1 ^ bor;
    g2       = ~h1 & bor;
    bor_nxt  = g1 | g2;
    r_nxt    = {d, r_sh[WIDTH-1:1]};
`ifdef SERIAL_SUB_SAT_EN
    diff_fin = bor_nxt ? '0 : r_nxt;
`else
    diff_fin = r_nxt;
`endif
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state    <= StIdle;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      bor      <= 1'b0;
      cnt      <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      diff_out <= '0;
      bo_out   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start_in) begin
            a_sh     <= a_in;
            b_sh     <= b_in;
            bor      <= 1'b0;
            cnt      <= '0;
            busy_out <= 1'b1;
            state    <= StRun;
          end
        end
        StRun: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          r_sh <= r_nxt;
          bor  <= bor_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CntLast) begin
            diff_out <= diff_fin;
            bo_out   <= bor_nxt;
            done_out <= 1'b1;
            state    <= StDone;
          end
        end
        StDone: begin
          done_out <= 1'b0;
          busy_out <= 1'b0;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtractor controller. It computes A − B for WIDTH-bit operands over WIDTH clock cycles, processing one bit per cycle LSB-first. The datapath is one 1-bit full-subtract cell, built as two cascaded half-subtract cells plus a borrow flop. The block sits beside the combinational subtract cells and sequences them: operand capture, shifting, borrow chaining, and a start/busy/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.

- clk_in  input  1  clock; all logic on the rising edge.
- rst_n_in  input  1  reset, synchronous and active-low.
- start_in  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  minuend; captured on the accepted start edge.
- b_in  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy_out  output  1  high in RUN and DONE.
- done_out  output  1  one-cycle completion pulse.
- diff_out  output  WIDTH  registered result; holds until the next completion.
- bo_out  output  1  final borrow: 1 when A < B unsigned; holds with diff_out.

## Operation
- Internal registers:
  - a_sh, b_sh: WIDTH-bit operand shift registers.
  - r_sh: WIDTH-bit result shift register.
  - bor: 1-bit borrow.
  - cnt: ceil(log2 WIDTH) bits.
  - state: 2 bits.
- States:
  - IDLE → RUN on start_in=1. On that edge: a_sh←a_in, b_sh←b_in, bor←0, cnt←0.
  - RUN: each edge processes bit 0 of a_sh and b_sh.
    - First half-subtract: h1 = a^b, g1 = ~a&b.
    - Second half-subtract: d = h1^bor, g2 = ~h1&bor.
    - Updates: bor←g1|g2; r_sh←{d, r_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1, zero-fill; cnt←cnt+1.
  - RUN → DONE on the edge where cnt==WIDTH-1. On that edge: diff_out←{d, r_sh[WIDTH-1:1]}, bo_out←g1|g2, done_out←1.
  - DONE → IDLE unconditionally on the next edge; done_out←0.
- Handshake:
  - start_in is ignored while busy_out=1. It is not queued.
  - A start held high is re-accepted on the first IDLE cycle.
- Arithmetic: the result is A − B mod 2^WIDTH, unsigned. bo_out equals the borrow out of the MSB.
- Reset: rst_n_in=0 at any edge, including mid-RUN, forces the following. The partial operation is discarded and no done_out is produced.
  - state=IDLE
  - busy_out=0, done_out=0, diff_out=0, bo_out=0
  - all internal registers = 0
- Reset values of outputs: busy_out=0, done_out=0, diff_out=0, bo_out=0.

## Timing
- Start accepted at edge E0 → RUN occupies edges E1..E_WIDTH → done_out, diff_out and bo_out are valid in the cycle after edge E_WIDTH.
- Latency: WIDTH+1 cycles from the accepting edge to the done_out cycle.
- Throughput: one operation per WIDTH+2 cycles (E0, WIDTH RUN edges, DONE edge).
- busy_out rises in the cycle after E0 and falls in the cycle after the DONE→IDLE edge.
- diff_out and bo_out change only on the completion edge and on reset.

## Configuration
- Macro SERIAL_SUB_SAT_EN.
  - Defined: on completion, if the final borrow is 1, diff_out←0 (saturate at zero). bo_out is still set to 1.
  - Undefined: diff_out is always the wrapped two's-complement difference.

## Test plan
- WIDTH=8; a_in=200, b_in=55, start_in pulsed 1 cycle → done_out high exactly 9 cycles after the accepting edge; diff_out=145, bo_out=0; busy_out high for 9 cycles.
- a_in=5, b_in=9 → diff_out=252 (0xFC), bo_out=1. With SERIAL_SUB_SAT_EN defined: diff_out=0, bo_out=1.
- Boundary operands:
  - a_in=0, b_in=0 → diff_out=0, bo_out=0.
  - a_in=0, b_in=255 → diff_out=1, bo_out=1; diff_out=0 under SERIAL_SUB_SAT_EN.
  - a_in=255, b_in=0 → diff_out=255, bo_out=0.
- start_in pulsed with a_in=10, b_in=3; start_in pulsed again mid-RUN with a_in=1, b_in=2 → one done_out only; diff_out=7, bo_out=0.
- start_in held high continuously with fixed a_in=100, b_in=1 → done_out pulses every 10 cycles; diff_out=99 each time.
- Reset mid-RUN: rst_n_in=0 for 1 cycle at cycle 4 of RUN → all outputs 0, no done_out; a new start then completes normally.
